// File: rtl/pcie_tx_gearbox.sv
//-----------------------------------------------------------------------------
// pcie_tx_gearbox
//
// 128b/130b transmit gearbox. Accepts one 130-bit block per handshake
// (2-bit sync header followed by a 128-bit scrambled payload, both LSB
// first) and repacks the bit stream into OUT_W-bit words for the lane
// serializer. Bit 0 of every word is the oldest bit on the wire.
//
// Parameters:
//   OUT_W     output word width, 32 or 64 (must stay below 130)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset; discards all buffered bits
//   in_valid   block present on in_data / in_sync
//   in_ready   gearbox accepts a block this cycle (registered)
//   in_data    128-bit scrambled payload, bit 0 transmitted first
//   in_sync    2-bit sync header, bit 0 transmitted first
//   out_valid  out_data holds OUT_W valid bits (registered)
//   out_ready  serializer consumes the word this cycle
//   out_data   packed stream word, bit 0 oldest (straight from the buffer)
//   blk_cnt    count of accepted blocks, wraps 16'hFFFF -> 0
//   sync_err   sticky illegal-sync-header flag
//
// Build option:
//   PCIE_GEARBOX_SYNC_CHK_EN  when defined, a push carrying sync header
//                             2'b00 or 2'b11 sets sync_err (sticky until
//                             reset). When undefined, sync_err is tied to 0
//                             and no check logic exists.
//-----------------------------------------------------------------------------
module pcie_tx_gearbox #(
    parameter int OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [1:0]       in_sync,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [15:0]      blk_cnt,
    output logic             sync_err
);

    // Block width on the wire and buffer capacity. With in_ready limited to
    // fill <= 2*OUT_W-1, the worst case after a push is 2*OUT_W-1+130 bits,
    // which is exactly BUF_W, so the buffer can never overflow.
    localparam int BLK_W  = 130;
    localparam int BUF_W  = 2 * OUT_W + 129;
    localparam int FILL_W = $clog2(BUF_W + 1);

    localparam logic [FILL_W-1:0] OUT_W_F   = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] BLK_W_F   = FILL_W'(BLK_W);
    localparam logic [FILL_W-1:0] RDY_MAX_F = FILL_W'(2 * OUT_W - 1);

    // State
    logic [BUF_W-1:0]  bit_buf_r;
    logic [FILL_W-1:0] fill_r;
    logic [15:0]       blk_cnt_r;
    logic              in_ready_r;
    logic              out_valid_r;

    // Next-state and datapath helpers
    logic              push_s;
    logic              pop_s;
    logic [BUF_W-1:0]  shifted_s;
    logic [FILL_W-1:0] base_fill_s;
    logic [BUF_W-1:0]  blk_ext_s;
    logic [BUF_W-1:0]  blk_ins_s;
    logic [BUF_W-1:0]  bit_buf_nxt_s;
    logic [FILL_W-1:0] fill_nxt_s;

    // Handshake events. in_ready/out_valid are registers, so neither event
    // has a combinational path from the opposite side's handshake input.
    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // A pop retires the oldest OUT_W bits first; zeros shift in at the top
    // so every bit above fill stays 0.
    assign shifted_s   = pop_s ? (bit_buf_r >> OUT_W) : bit_buf_r;
    assign base_fill_s = pop_s ? (fill_r - OUT_W_F) : fill_r;

    // New block, header in the two least significant (first-sent) bits,
    // positioned directly above the surviving bits. Because the bits above
    // fill are always zero, an OR is enough to merge it in.
    assign blk_ext_s = {{(BUF_W - BLK_W){1'b0}}, in_data, in_sync};
    assign blk_ins_s = blk_ext_s << base_fill_s;

    // Buffer and fill-level next state for the four push/pop combinations
    always_comb begin
        bit_buf_nxt_s = bit_buf_r;
        fill_nxt_s    = fill_r;
        case ({push_s, pop_s})
            2'b11: begin
                bit_buf_nxt_s = shifted_s | blk_ins_s;
                fill_nxt_s    = base_fill_s + BLK_W_F;
            end
            2'b10: begin
                bit_buf_nxt_s = shifted_s | blk_ins_s;
                fill_nxt_s    = base_fill_s + BLK_W_F;
            end
            2'b01: begin
                bit_buf_nxt_s = shifted_s;
                fill_nxt_s    = base_fill_s;
            end
            2'b00: begin
                bit_buf_nxt_s = bit_buf_r;
                fill_nxt_s    = fill_r;
            end
            default: begin
                bit_buf_nxt_s = bit_buf_r;
                fill_nxt_s    = fill_r;
            end
        endcase
    end

    // Buffer, fill level and the handshake flags derived from the next fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf_r   <= {BUF_W{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            bit_buf_r   <= bit_buf_nxt_s;
            fill_r      <= fill_nxt_s;
            in_ready_r  <= (fill_nxt_s <= RDY_MAX_F);
            out_valid_r <= (fill_nxt_s >= OUT_W_F);
        end
    end

    // Accepted-block counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_r <= 16'd0;
        end else if (push_s) begin
            blk_cnt_r <= blk_cnt_r + 16'd1;
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = bit_buf_r[OUT_W-1:0];
    assign blk_cnt   = blk_cnt_r;

`ifdef PCIE_GEARBOX_SYNC_CHK_EN
    // A legal 128b/130b sync header has exactly one bit set (odd parity)
    function automatic logic sync_hdr_legal(input logic [1:0] hdr);
        return hdr[1] ^ hdr[0];
    endfunction

    logic sync_err_r;

    // Sticky illegal-header flag; the offending block is still packed as-is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_r <= 1'b0;
        end else if (push_s && !sync_hdr_legal(in_sync)) begin
            sync_err_r <= 1'b1;
        end else begin
            sync_err_r <= sync_err_r;
        end
    end

    assign sync_err = sync_err_r;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_tx_gearbox.sv
//-----------------------------------------------------------------------------
// tb_pcie_tx_gearbox
//
// Scoreboard bench for pcie_tx_gearbox (OUT_W = 64). Every accepted block
// appends its 130 bits (header first, LSB first) to a bit queue; a monitor
// compares out_data against the oldest queued bits every cycle and retires
// OUT_W bits per consumed word. Directed sequences add hand-computed checks.
//-----------------------------------------------------------------------------
module tb_pcie_tx_gearbox;

    localparam int OUT_W = 64;

`ifdef PCIE_GEARBOX_SYNC_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [1:0]       in_sync;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [15:0]      blk_cnt;
    logic             sync_err;

    pcie_tx_gearbox #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sync   (in_sync),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .blk_cnt   (blk_cnt),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard state
    bit          q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic        exp_err = 1'b0;
    int          pop_cnt = 0;

    // Monitor: compare the presented word and flags with the bit queue,
    // then apply this cycle's pop and push to the queue.
    always @(negedge clk) begin
        int          sz;
        logic [63:0] w;
        logic        push, pop;
        if (!rst_n) begin
            q.delete();
            exp_cnt = 16'd0;
            exp_err = 1'b0;
        end else begin
            sz = q.size();
            w  = 64'd0;
            for (int i = 0; i < 64 && i < sz; i++) w[i] = q[i];
            chk("mon_out_valid", out_valid, (sz >= 64));
            chk("mon_in_ready",  in_ready,  (sz <= 127));
            chk("mon_out_data",  out_data,  w);
            chk("mon_blk_cnt",   blk_cnt,   exp_cnt);
            chk("mon_sync_err",  sync_err,  exp_err);
            push = in_valid && (sz <= 127);
            pop  = out_ready && (sz >= 64);
            if (pop) begin
                for (int i = 0; i < 64; i++) void'(q.pop_front());
                pop_cnt++;
            end
            if (push) begin
                for (int i = 0; i < 2; i++)   q.push_back(in_sync[i]);
                for (int i = 0; i < 128; i++) q.push_back(in_data[i]);
                exp_cnt = exp_cnt + 16'd1;
                if (EXP_ERR && (in_sync == 2'b00 || in_sync == 2'b11)) exp_err = 1'b1;
            end
        end
    end

    localparam logic [127:0] D0 = 128'h0123456789ABCDEF_FEDCBA9876543210;

    function automatic logic [127:0] blk_data(input int k);
        logic [31:0] kk;
        kk = k[31:0];
        return {32'hC0DE_0000 ^ kk, ~kk, kk * 32'd3, 32'h1357_9BDF + kk};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse with checks of the values held during reset
    task automatic do_reset;
        in_valid  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  64'd0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_blk_cnt",   blk_cnt,   16'd0);
        chk("rst_sync_err",  sync_err,  1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    // From empty: one push with no pop (130), then one pop (66)
    task automatic to_fill_66;
        in_valid  = 1'b1;
        in_data   = D0;
        in_sync   = 2'b10;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("fill66_out_valid", out_valid, 1'b1);
        chk("fill66_in_ready",  in_ready,  1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, bubbles, base_pop, cyc;
        logic accepted, saw_stall;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 128'd0; in_sync = 2'b10; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_out_data",  out_data,  64'd0);
        chk("init_in_ready",  in_ready,  1'b1);
        chk("init_blk_cnt",   blk_cnt,   16'd0);
        tick();
        rst_n = 1'b1;

        // Single block, header 2'b10
        in_valid = 1'b1; in_data = D0; in_sync = 2'b10; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_w0",        out_data,  64'hFB72EA61D950C842);
        chk("single_w0_valid",  out_valid, 1'b1);
        tick();
        @(negedge clk);
        chk("single_w1",        out_data,  64'h048D159E26AF37BF);
        tick();
        @(negedge clk);
        chk("single_tail_valid", out_valid, 1'b0);
        chk("single_tail_data",  out_data,  64'd0);
        chk("single_blk_cnt",    blk_cnt,   16'd1);

        // Mid-stream reset with 66 bits buffered
        do_reset();
        to_fill_66();
        do_reset();
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_in_ready",  in_ready,  1'b1);

        // Simultaneous push and pop at fill 66 -> 132, header at [3:2]
        to_fill_66();
        tick();
        in_valid = 1'b1; in_data = blk_data(7); in_sync = 2'b01; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("pp_in_ready",  in_ready,      1'b0);
        chk("pp_out_valid", out_valid,     1'b1);
        chk("pp_hdr_pos",   out_data[3:2], 2'b01);
        chk("pp_old_bits",  out_data[1:0], 2'b00);
        out_ready = 1'b1;
        repeat (4) tick();

        // Illegal sync header
        do_reset();
        in_valid = 1'b1; in_data = blk_data(3); in_sync = 2'b11; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("sync_err_set", sync_err, EXP_ERR);
        repeat (5) tick();
        @(negedge clk);
        chk("sync_err_sticky", sync_err, EXP_ERR);

        // Continuous stream of 64 blocks
        do_reset();
        out_ready = 1'b1;
        sent = 0; bubbles = 0; cyc = 0;
        base_pop = pop_cnt;
        in_valid = 1'b1; in_data = blk_data(0); in_sync = 2'b01;
        while ((pop_cnt - base_pop) < 130 && cyc < 600) begin
            @(negedge clk);
            if (cyc == 0) chk("stream_cycle0_valid", out_valid, 1'b0);
            else if (!out_valid) bubbles++;
            accepted = in_valid && in_ready;
            tick();
            if (accepted) begin
                sent++;
                if (sent < 64) begin
                    in_data = blk_data(sent);
                    in_sync = (sent % 5 == 0) ? 2'b01 : 2'b10;
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        @(negedge clk);
        chk("stream_words",   pop_cnt - base_pop, 130);
        chk("stream_bubbles", bubbles, 0);
        chk("stream_blk_cnt", blk_cnt, 16'd64);
        chk("stream_empty",   out_valid, 1'b0);

        // Backpressure: out_ready low for 10 cycles while 16 blocks stream
        do_reset();
        out_ready = 1'b0; sent = 0; cyc = 0; saw_stall = 1'b0;
        in_valid = 1'b1; in_data = blk_data(100); in_sync = 2'b10;
        while (sent < 16 && cyc < 300) begin
            if (cyc == 10) out_ready = 1'b1;
            @(negedge clk);
            if (!in_ready && !out_ready) saw_stall = 1'b1;
            accepted = in_valid && in_ready;
            tick();
            if (accepted) begin
                sent++;
                in_data = blk_data(100 + sent);
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        @(negedge clk);
        chk("bp_stall_seen", saw_stall, 1'b1);
        chk("bp_blocks",     sent,      16);
        chk("bp_blk_cnt",    blk_cnt,   16'd16);
        chk("bp_drained",    out_valid, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcie_tx_gearbox.md
Name: pcie_tx_gearbox

Overview:
- 128b/130b transmit gearbox. Sits directly downstream of the TX scrambler: takes 128-bit scrambled payloads plus a 2-bit sync header and packs the resulting 130-bit blocks into a continuous OUT_W-bit stream for the lane serializer.
- Valid/ready on both sides.
- Bits are transmitted LSB first. Within each block, the sync header goes first, then the payload.

Parameters:
- OUT_W, 64, output word width. Legal values: 32 or 64 (must be < 130).
- BUF_W, 2*OUT_W+129, bit-buffer capacity. Derived; not overridden.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  block present on in_data/in_sync
- in_ready  output  1  gearbox accepts block this cycle
- in_data  input  128  scrambled payload; bit 0 transmitted first
- in_sync  input  2  sync header: 2'b10 = data block, 2'b01 = ordered set; bit 0 transmitted first
- out_valid  output  1  out_data holds OUT_W valid bits
- out_ready  input  1  serializer consumes word this cycle
- out_data  output  OUT_W  packed stream; bit 0 oldest
- blk_cnt  output  16  count of accepted blocks, wraps at 16'hFFFF->0
- sync_err  output  1  sticky illegal-sync flag (exists only with the optional feature)

Behaviour:
- State:
  - buf[BUF_W-1:0]: bit buffer, LSB = oldest bit.
  - fill: count of valid bits, range 0..BUF_W.
- Reset (async, rst_n low):
  - buf = 0, fill = 0, blk_cnt = 0, sync_err = 0.
  - Therefore out_valid = 0, out_data = 0, in_ready = 1.
  - Reset asserted mid-stream discards all buffered bits. Nothing partial is emitted.
- Handshake signals:
  - in_ready = (fill <= 2*OUT_W-1). Depends only on registered fill; no combinational path from out_ready.
  - out_valid = (fill >= OUT_W).
  - out_data = buf[OUT_W-1:0], driven straight from the register.
- Events per cycle:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Update per cycle:
  - pop only: buf >>= OUT_W (zero-fill at top); fill -= OUT_W.
  - push only: buf[fill +: 130] = {in_data, in_sync}; fill += 130; blk_cnt++.
  - push and pop together: shift first, then insert the new block at offset fill-OUT_W; fill += 130-OUT_W.
  - neither: hold.
- Unused buffer bits above fill are always 0.
- Latency: a block pushed in cycle N has its first bits on out_data in cycle N+1. Its header occupies out_data[fill_N+1:fill_N] if fill_N < OUT_W.
- Throughput: with in_valid held at 1 and out_ready held at 1, out_valid deasserts only in cycle 0 after the first push. No bubbles occur afterwards. Max fill = 2*OUT_W-1+130 = BUF_W, so the buffer never overflows.
- Backpressure:
  - When out_ready = 0, pops stop. Once fill reaches 2*OUT_W or more, in_ready drops.
  - Upstream must hold in_data/in_sync stable while in_valid=1 and in_ready=0. The block does not check this.
- fill never underflows, because a pop requires fill >= OUT_W.
- in_sync is passed through unchanged in all builds.

Optional Feature:
- Macro: PCIE_GEARBOX_SYNC_CHK_EN.
- Defined:
  - On a push with in_sync equal to 2'b00 or 2'b11, sync_err is set the following cycle.
  - sync_err stays set until reset.
  - The block is still packed unmodified.
- Undefined:
  - The sync_err port is present but tied to 0.
  - No check logic is synthesized.

Test Plan:
- Reset, OUT_W=64 -> out_valid=0, out_data=0, in_ready=1, blk_cnt=0. Assert rst_n low mid-stream with fill=66 -> fill=0, out_valid=0 on the next edge.
- Single push, in_sync=2'b10, in_data=128'h0123456789ABCDEF_FEDCBA9876543210, out_ready=1:
  - cycle+1: out_data={in_data[61:0],2'b10}.
  - cycle+2: out_data=in_data[125:62].
  - then fill=2, out_valid=0.
- Continuous stream of 64 blocks, in_valid=1, out_ready=1 -> exactly 130 output words.
  - Concatenated output equals the concatenated blocks.
  - out_valid stays high from the second cycle onward.
  - blk_cnt=64.
- Backpressure: out_ready=0 for 10 cycles while upstream streams.
  - in_ready drops once fill >= 128.
  - No bits are lost or duplicated after out_ready returns to 1.
  - Max observed fill <= 257.
- Simultaneous push and pop at fill=66 -> next fill=132. Header bits land at out_data[3:2] of the following word.
- With PCIE_GEARBOX_SYNC_CHK_EN defined: push in_sync=2'b11 -> sync_err=1 next cycle and stays 1. Without the macro, the same stimulus leaves sync_err=0.
- blk_cnt wrap: 65536 pushes -> blk_cnt=0.
